// File: rtl/huc_psram_ctrl.sv
// HuCard mapper channel to 16-bit asynchronous PSRAM: one fixed-length, wait-stated read or write per CPU strobe edge.
// Optional one-word read cache enabled by defining HUC_PSRAM_WCACHE_EN.
module huc_psram_ctrl #(
  parameter int T_RD = 4,
  parameter int T_WR = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_dati,
  input  logic        req_ce,
  input  logic        req_ce2,
  input  logic        req_oe,
  input  logic        req_we,
  output logic [7:0]  req_dato,
  output logic        busy,
  output logic        ovr,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_dq_o,
  output logic        mem_dq_oe,
  input  logic [15:0] mem_dq_i,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_ub_n,
  output logic        mem_lb_n
);

  typedef enum logic [1:0] {IDLE, RD, WR, RECOV} state_t;

  localparam logic [3:0] RD_LOAD = 4'(T_RD - 1);
  localparam logic [3:0] WR_LOAD = 4'(T_WR - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ce2_q;
  logic        lsb_q, lsb_nxt;
  logic        start;
  logic        cache_hit;
  logic [15:0] hit_word;
  logic [18:0] addr_nxt;
  logic [15:0] dq_o_nxt;
  logic [7:0]  dato_nxt;
  logic        ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt;
  logic        dq_oe_nxt, busy_nxt, ovr_nxt;

  assign start = req_ce2 && !ce2_q && req_ce && (req_oe || req_we);

`ifdef HUC_PSRAM_WCACHE_EN
  logic        c_valid;
  logic [18:0] c_tag;
  logic [15:0] c_data;

  assign cache_hit = c_valid && (c_tag == req_addr[19:1]);
  assign hit_word  = c_data;

  // Filled by every completed PSRAM read; writes to the cached word patch the addressed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (state == RD && cnt == 4'd0) begin
      c_valid <= 1'b1;
      c_tag   <= mem_addr;
      c_data  <= mem_dq_i;
    end else if (state == IDLE && start && req_we && cache_hit) begin
      if (req_addr[0]) c_data[15:8] <= req_dati;
      else             c_data[7:0]  <= req_dati;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_word  = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ce2_q     <= 1'b0;
      lsb_q     <= 1'b0;
      mem_addr  <= '0;
      mem_dq_o  <= '0;
      req_dato  <= 8'hFF;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_ub_n  <= 1'b1;
      mem_lb_n  <= 1'b1;
      mem_dq_oe <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ce2_q     <= req_ce2;
      lsb_q     <= lsb_nxt;
      mem_addr  <= addr_nxt;
      mem_dq_o  <= dq_o_nxt;
      req_dato  <= dato_nxt;
      mem_ce_n  <= ce_n_nxt;
      mem_oe_n  <= oe_n_nxt;
      mem_we_n  <= we_n_nxt;
      mem_ub_n  <= ub_n_nxt;
      mem_lb_n  <= lb_n_nxt;
      mem_dq_oe <= dq_oe_nxt;
      busy      <= busy_nxt;
      ovr       <= ovr_nxt;
    end
  end

  // Next-state and next-output values; strobes default to inactive so RECOV and IDLE need no explicit drive.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lsb_nxt   = lsb_q;
    addr_nxt  = mem_addr;
    dq_o_nxt  = mem_dq_o;
    dato_nxt  = req_dato;
    ce_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    ub_n_nxt  = 1'b1;
    lb_n_nxt  = 1'b1;
    dq_oe_nxt = 1'b0;
    ovr_nxt   = start && (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt = req_addr[19:1];
          lsb_nxt  = req_addr[0];
          if (req_we) begin
            state_nxt = WR;
            cnt_nxt   = WR_LOAD;
            ce_n_nxt  = 1'b0;
            we_n_nxt  = 1'b0;
            dq_oe_nxt = 1'b1;
            dq_o_nxt  = {req_dati, req_dati};
            ub_n_nxt  = !req_addr[0];
            lb_n_nxt  = req_addr[0];
          end else if (cache_hit) begin
            dato_nxt = req_addr[0] ? hit_word[15:8] : hit_word[7:0];
          end else begin
            state_nxt = RD;
            cnt_nxt   = RD_LOAD;
            ce_n_nxt  = 1'b0;
            oe_n_nxt  = 1'b0;
            ub_n_nxt  = !req_addr[0];
            lb_n_nxt  = req_addr[0];
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          state_nxt = RECOV;
          dato_nxt  = lsb_q ? mem_dq_i[15:8] : mem_dq_i[7:0];
        end else begin
          cnt_nxt  = cnt - 4'd1;
          ce_n_nxt = 1'b0;
          oe_n_nxt = 1'b0;
          ub_n_nxt = !lsb_q;
          lb_n_nxt = lsb_q;
        end
      end
      WR: begin
        // Data stays driven through RECOV so the PSRAM sees hold time after WE# rises.
        dq_oe_nxt = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = RECOV;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          ce_n_nxt = 1'b0;
          we_n_nxt = 1'b0;
          ub_n_nxt = !lsb_q;
          lb_n_nxt = lsb_q;
        end
      end
      RECOV: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: doc/huc_psram_ctrl.md
Name: huc_psram_ctrl

Overview:
- Downstream of the HuCard mapper: consumes one mapper memory-request channel (ROM or RAM) and runs the cycle on an external 16-bit asynchronous PSRAM.
- Returns the selected byte as the channel's read data.
- Converts the CPU access strobe into a fixed-length, wait-stated PSRAM read or write.
- One instance per channel; the mapper selects between instance outputs.

Parameters:
- T_RD, 4, PSRAM read strobe length in clk cycles (1..15).
- T_WR, 3, PSRAM write-enable low length in clk cycles (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_addr  in  20  byte address from mapper.
- req_dati  in  8  write data from mapper.
- req_ce  in  1  channel select from mapper.
- req_ce2  in  1  CPU access strobe; a rising edge starts an access.
- req_oe  in  1  read request.
- req_we  in  1  write request.
- req_dato  out  8  read data to mapper; held until the next read completes.
- busy  out  1  an access is in progress.
- ovr  out  1  one-cycle pulse: a start edge was dropped.
- mem_addr  out  19  PSRAM word address, req_addr[19:1].
- mem_dq_o  out  16  PSRAM write data; byte replicated on both lanes.
- mem_dq_oe  out  1  PSRAM data bus drive enable.
- mem_dq_i  in  16  PSRAM read data.
- mem_ce_n  out  1  PSRAM chip enable, active low.
- mem_oe_n  out  1  PSRAM output enable, active low.
- mem_we_n  out  1  PSRAM write enable, active low.
- mem_ub_n  out  1  upper byte lane enable (req_addr[0]=1), active low.
- mem_lb_n  out  1  lower byte lane enable (req_addr[0]=0), active low.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n = 1.
  - mem_dq_oe=0, mem_addr=0, mem_dq_o=0.
  - req_dato=8'hFF, busy=0, ovr=0.
  - FSM=IDLE, counter=0, ce2 edge register=0.
  - Reset mid-access aborts the access; strobes deassert immediately, not waiting for a clock edge.
- Start condition, evaluated at clk edge n: req_ce2=1, registered previous ce2=0, req_ce=1, and (req_oe|req_we)=1.
- Conditions at the start edge:
  - req_ce=0, or req_oe=req_we=0: ignored, no ovr.
  - req_we=1 and req_oe=1: treated as a write.
- Address, lanes and write data are latched at the start edge. Later changes on req_* do not affect the running access.
- FSM states: IDLE, RD, WR, RECOV. All outputs are registered.
- IDLE to RD (read start), from edge n:
  - Cycles n+1 .. n+T_RD: mem_ce_n=0, mem_oe_n=0, lane enable low for the addressed byte only.
  - At the end of the last RD cycle, req_dato captures mem_dq_i[15:8] if addr[0]=1, else mem_dq_i[7:0].
  - req_dato is valid from cycle n+T_RD+1. Default (T_RD=4): valid at n+5.
- IDLE to WR (write start), from edge n:
  - Cycles n+1 .. n+T_WR: mem_ce_n=0, mem_we_n=0, mem_dq_oe=1, mem_dq_o={dati,dati}, addressed lane low.
  - mem_oe_n stays 1 for the whole write.
- RECOV: one cycle after RD or WR.
  - All strobes and lanes are 1.
  - After a write, mem_dq_oe stays 1 (data hold); it is 0 after a read.
  - RECOV then returns to IDLE.
- busy = 1 in RD, WR and RECOV; 0 in IDLE.
  - Minimum start-to-start spacing: T_RD+2 cycles for a read, T_WR+2 for a write.
- A start condition while busy=1: access dropped; ovr=1 for exactly the next cycle; running access unaffected.
- Counter: 4-bit down-counter, loaded with T_RD-1 or T_WR-1 on entry; leave the state when the count reaches 0.
- req_dato is never modified by writes (without the cache feature).

Optional Feature:
- Macro: HUC_PSRAM_WCACHE_EN.
- Enabled: a one-word read cache (19-bit tag, 16-bit data, valid bit).
  - Read hit (valid, tag=addr[19:1]): req_dato updates at n+1, no PSRAM cycle, busy stays 0.
  - Read miss: normal RD; the full word fills the cache; valid set.
  - Write to the tagged word: updates the addressed byte in the cache.
  - Reset clears valid.
- Disabled: every read runs a PSRAM cycle; no cache registers synthesized.

Test Plan:
- Reset: hold rst_n=0, then release -> req_dato=8'hFF, all mem_*_n=1, busy=0, mem_dq_oe=0.
- Read, addr=20'h00001, mem_dq_i=16'hA55A, ce2 edge at n -> ub_n=0, lb_n=1, oe_n low n+1..n+4, req_dato=8'hA5 at n+5, busy=0 at n+6.
- Write, addr=20'h00100, dati=8'h3C -> mem_addr=19'h00080, lb_n=0, we_n low n+1..n+3, dq_o=16'h3C3C, dq_oe=1 through n+4, oe_n=1 throughout.
- Second ce2 edge 2 cycles after a read start -> ovr=1 for one cycle, first read completes normally, no second PSRAM cycle.
- ce2 edge with req_ce=0, or with oe=we=0 -> no strobe activity, busy=0, ovr=0.
- HUC_PSRAM_WCACHE_EN: read addr 0x2, then read addr 0x3 -> the second read returns mem_dq_i[15:8] from the first fetch at n+1, with mem_ce_n=1 throughout the second read.
